// File: rtl/intf_sink_collector.sv
// Sink-side lane collector: detects per-lane changes, scans them round-robin into an event FIFO.
// Optional build macro INTF_SINK_TIMESTAMP_EN adds a 16-bit push timestamp on output evt_time.
module intf_sink_collector #(
    parameter int N     = 6,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             lane_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [LW-1:0]            evt_lane,
    output logic                     evt_value,
    output logic [N-1:0]             pending,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   evt_count
`ifdef INTF_SINK_TIMESTAMP_EN
    ,
    output logic [15:0]              evt_time
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  samp_q, samp_d;
    logic          init_q, init_d;
    logic [N-1:0]  pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic [LW-1:0] rr_q, rr_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] lane_mem_q [DEPTH];
    logic [LW-1:0] lane_mem_d [DEPTH];
    logic [DEPTH-1:0] val_mem_q, val_mem_d;
`ifdef INTF_SINK_TIMESTAMP_EN
    logic [15:0]   ts_q, ts_d;
    logic [15:0]   time_mem_q [DEPTH];
    logic [15:0]   time_mem_d [DEPTH];
`endif

    logic [N-1:0]  chg_s;
    logic [N-1:0]  clr_s;
    logic [LW:0]   idx_s;
    logic [LW-1:0] sel_s;
    logic          found_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;

    // The first cycle after reset only seeds the sampler, so lanes already high raise nothing.
    always_comb begin
        samp_d = lane_in;
        init_d = 1'b0;
        if (init_q) begin
            chg_s = {N{1'b0}};
        end else begin
            chg_s = lane_in ^ samp_q;
        end
    end

    // Round-robin pick: first pending lane at or after rr_q, wrapping past N-1.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {LW{1'b0}};
        idx_s   = {(LW+1){1'b0}};
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, rr_q} + (LW+1)'(k);
            if (idx_s >= (LW+1)'(N)) begin
                idx_s = idx_s - (LW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && pending_q[idx_s[LW-1:0]]) begin
                found_s = 1'b1;
                sel_s   = idx_s[LW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Fullness is judged on the registered count, before any same-cycle pop.
    always_comb begin
        valid_s = (count_q != {CW{1'b0}});
        pop_s   = valid_s && evt_ready;
        push_s  = found_s && (count_q < CW'(DEPTH));
        if (push_s) begin
            clr_s = {{(N-1){1'b0}}, 1'b1} << sel_s;
        end else begin
            clr_s = {N{1'b0}};
        end
    end

    // A change landing on a lane that is still pending (and not being queued now) loses an edge.
    always_comb begin
        pending_d  = (pending_q & ~clr_s) | chg_s;
        overflow_d = overflow_q | (|(chg_s & pending_q & ~clr_s));
        if (push_s) begin
            if (sel_s == LW'(N - 1)) begin
                rr_d = {LW{1'b0}};
            end else begin
                rr_d = sel_s + LW'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        lane_mem_d = lane_mem_q;
        val_mem_d  = val_mem_q;
`ifdef INTF_SINK_TIMESTAMP_EN
        time_mem_d = time_mem_q;
        ts_d       = ts_q + 16'd1;
`endif
        wr_d       = wr_q;
        rd_d       = rd_q;
        if (push_s) begin
            lane_mem_d[wr_q] = sel_s;
            val_mem_d[wr_q]  = samp_q[sel_s];
`ifdef INTF_SINK_TIMESTAMP_EN
            time_mem_d[wr_q] = ts_q;
`endif
            wr_d = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q     <= {N{1'b0}};
            init_q     <= 1'b1;
            pending_q  <= {N{1'b0}};
            overflow_q <= 1'b0;
            rr_q       <= {LW{1'b0}};
            wr_q       <= {PW{1'b0}};
            rd_q       <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            val_mem_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                lane_mem_q[i] <= {LW{1'b0}};
            end
`ifdef INTF_SINK_TIMESTAMP_EN
            ts_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                time_mem_q[i] <= 16'd0;
            end
`endif
        end else begin
            samp_q     <= samp_d;
            init_q     <= init_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            rr_q       <= rr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            val_mem_q  <= val_mem_d;
            lane_mem_q <= lane_mem_d;
`ifdef INTF_SINK_TIMESTAMP_EN
            ts_q       <= ts_d;
            time_mem_q <= time_mem_d;
`endif
        end
    end

    assign evt_valid = valid_s;
    assign evt_lane  = lane_mem_q[rd_q];
    assign evt_value = val_mem_q[rd_q];
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign evt_count = count_q;
`ifdef INTF_SINK_TIMESTAMP_EN
    assign evt_time  = time_mem_q[rd_q];
`endif

endmodule

// File: doc/intf_sink_collector.md
Name: intf_sink_collector

Overview:
Sink-side consumer for an array of N single-bit interface lanes, each driven through the source modport of its `intf` instance. The block detects per-lane value changes and queues them as events. Events are scanned round-robin into a small FIFO and presented on a valid/ready event port. Together with the source-side drivers it closes the loop: drivers write lanes, this block reads them and reports activity to a downstream checker or controller.

Parameters:
N, 6, number of lanes (interface array elements), 2..32
DEPTH, 4, event FIFO depth, power of two, 2..16
LW, $clog2(N), lane-index width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
lane_in  input  N  lane_in[i] = logic_in_intf of array element i, via the sink modport
evt_valid  output  1  event available at FIFO head
evt_ready  input  1  consumer accepts head event
evt_lane  output  LW  lane index of head event
evt_value  output  1  lane value captured when the event was queued
pending  output  N  lanes with a detected but not-yet-queued change
overflow  output  1  sticky: a change was lost
evt_count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release). Clears: samp=0, pending=0, rr_ptr=0, FIFO empty, overflow=0, init=1. Outputs while in reset: evt_valid=0, evt_lane=0, evt_value=0, evt_count=0.
- Sampling, every cycle: samp <= lane_in.
- First cycle after reset (init=1):
  - samp loads without raising any change.
  - init <= 0.
  - Lanes that are already high at reset release produce no events.
- Change detect when init=0: chg = lane_in ^ samp. Then pending <= (pending & ~clr) | chg.
- Overflow: if chg[i] && pending[i] && !clr[i], set overflow (intermediate edge lost). Overflow clears only on reset.
- Scanner, at most one push per cycle:
  - Push only when pending != 0 and evt_count < DEPTH. Full is evaluated before any pop in the same cycle.
  - Selects the first set pending bit at index >= rr_ptr, wrapping past N-1 to 0.
  - Pushes {lane = sel, value = samp[sel]}.
  - Sets clr = one-hot(sel).
  - Updates rr_ptr <= sel+1, or 0 if sel == N-1.
- Same-cycle collision: if chg[sel] occurs in the same cycle as the push, pending[sel] stays 1. This is not an overflow, because the old change was queued.
- FIFO:
  - Pop on evt_valid && evt_ready.
  - Push and pop may occur together: count is unchanged, order is preserved.
  - Pointers wrap modulo DEPTH.
  - evt_lane and evt_value hold stable while evt_valid=1 and evt_ready=0.
- Latency: a lane toggle before edge E sets pending at E, is pushed at E+1, and evt_valid=1 after E+1 (2 cycles), assuming FIFO not full and no other pending lanes.
- FIFO full: pending accumulates, no push occurs, and the scanner resumes on the first cycle with count < DEPTH.
- Reset mid-operation: the FIFO and pending are discarded immediately. Queued events are not delivered.

Optional Feature:
INTF_SINK_TIMESTAMP_EN
- Defined:
  - Adds output evt_time [15:0].
  - A 16-bit free-running cycle counter resets to 0 and wraps 0xFFFF -> 0x0000.
  - Its value at the push cycle is stored with each event and presented with the head event.
- Undefined: the port, counter and storage are absent. All other behaviour is identical.

Test Plan:
- Reset release with lane_in=6'b010101 -> no events, pending=0, overflow=0 after 5 idle cycles.
- Hold evt_ready=1. From 0, toggle lane_in[3]=1 at cycle 10 -> evt_valid at cycle 12 with evt_lane=3, evt_value=1. Only one event.
- Hold evt_ready=0. Toggle lanes 0,2,4,5 simultaneously with rr_ptr=3 -> queue order 4,5,0,2 with all values 1, evt_count=4 (full).
- Keep FIFO full and toggle lane 1 twice (0->1->0) -> overflow=1, pending[1]=1. Release ready -> 4 queued events drain, then lane 1 event with evt_value=0.
- Push and pop on the same cycle at count=2 -> count stays 2 and the head advances in order. Assert rst mid-drain -> evt_valid=0 immediately, evt_count=0.
- With INTF_SINK_TIMESTAMP_EN: toggle lane 5 when the counter reads 0xFFFE -> evt_time=0xFFFF. A second toggle 2 cycles later -> evt_time=0x0001.
